// File: rtl/modem_ctl_monitor_pkg.sv
// Shared constants for the modem-control (DTR/RTS) receive monitor.
package modem_ctl_monitor_pkg;

   localparam logic MODEM_IDLE_LEVEL        = 1'b1;
   localparam int   DEFAULT_DEBOUNCE_CYCLES = 12000;
   localparam int   DEFAULT_COUNT_WIDTH     = 8;

   localparam logic CH_DTR = 1'b0;
   localparam logic CH_RTS = 1'b1;

   // Debounce counter must be able to hold DEBOUNCE_CYCLES-1 for any legal value.
   function automatic int debounce_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/modem_ctl_monitor_if.sv
// Modem-control monitor bus: raw host lines in, debounced status out.
// DSR/CTS exist only when MODEM_CTL_ECHO_EN is defined.
interface modem_ctl_monitor_if
   import modem_ctl_monitor_pkg::*;
#(
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);
   logic                   DTR;
   logic                   RTS;
   logic                   CLEAR;
   logic                   DTR_LEVEL;
   logic                   RTS_LEVEL;
   logic                   DTR_FALL;
   logic                   DTR_RISE;
   logic                   RTS_FALL;
   logic                   RTS_RISE;
   logic [COUNT_WIDTH-1:0] DTR_COUNT;
   logic [COUNT_WIDTH-1:0] RTS_COUNT;
`ifdef MODEM_CTL_ECHO_EN
   logic                   DSR;
   logic                   CTS;
`endif

   modport slave (
      input  DTR, RTS, CLEAR,
      output DTR_LEVEL, RTS_LEVEL, DTR_FALL, DTR_RISE, RTS_FALL, RTS_RISE,
`ifdef MODEM_CTL_ECHO_EN
      output DSR, CTS,
`endif
      output DTR_COUNT, RTS_COUNT
   );

   modport master (
      output DTR, RTS, CLEAR,
      input  DTR_LEVEL, RTS_LEVEL, DTR_FALL, DTR_RISE, RTS_FALL, RTS_RISE,
`ifdef MODEM_CTL_ECHO_EN
      input  DSR, CTS,
`endif
      input  DTR_COUNT, RTS_COUNT
   );

endinterface

// File: rtl/modem_ctl_channel.sv
// One modem-control line: 2-flop synchroniser, debounce, level/edge outputs
// and a wrapping assertion (fall) counter with synchronous clear.
module modem_ctl_channel
   import modem_ctl_monitor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int COUNT_WIDTH     = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   raw_in,
   input  logic                   clear,
   output logic                   level,
   output logic                   fall,
   output logic                   rise,
   output logic [COUNT_WIDTH-1:0] count
);

   localparam int               DB_W    = debounce_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic                   sync1_reg;
   logic                   sync2_reg;
   logic                   stable_reg;
   logic                   level_reg;
   logic                   fall_reg;
   logic                   rise_reg;
   logic [DB_W-1:0]        db_cnt_reg;
   logic [COUNT_WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         sync1_reg  <= MODEM_IDLE_LEVEL;
         sync2_reg  <= MODEM_IDLE_LEVEL;
         stable_reg <= MODEM_IDLE_LEVEL;
         level_reg  <= MODEM_IDLE_LEVEL;
         fall_reg   <= 1'b0;
         rise_reg   <= 1'b0;
         db_cnt_reg <= '0;
         count_reg  <= '0;
      end else begin
         sync1_reg <= raw_in;
         sync2_reg <= sync1_reg;

         // Any sample agreeing with the stable level restarts the qualification window.
         if (sync2_reg == stable_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
         end

         // Output stage: level and its edge pulses leave on the same edge.
         level_reg <= stable_reg;
         fall_reg  <= level_reg & ~stable_reg;
         rise_reg  <= ~level_reg & stable_reg;

         if (clear) begin
            count_reg <= '0;
         end else if (fall_reg) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign level = level_reg;
   assign fall  = fall_reg;
   assign rise  = rise_reg;
   assign count = count_reg;

endmodule

// File: rtl/modem_ctl_monitor.sv
// Top of the DTR/RTS monitor: two independent channels plus optional
// DSR/CTS echo registers (enabled by defining MODEM_CTL_ECHO_EN).
module modem_ctl_monitor
   import modem_ctl_monitor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int COUNT_WIDTH     = DEFAULT_COUNT_WIDTH
) (
   input  logic               CLK,
   input  logic               RESET,
   modem_ctl_monitor_if.slave bus
);

   logic [1:0]             raw_in;
   logic [1:0]             level;
   logic [1:0]             fall;
   logic [1:0]             rise;
   logic [COUNT_WIDTH-1:0] count [2];

   assign raw_in[CH_DTR] = bus.DTR;
   assign raw_in[CH_RTS] = bus.RTS;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         modem_ctl_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .COUNT_WIDTH     (COUNT_WIDTH)
         ) u_channel (
            .clk    (CLK),
            .srst   (RESET),
            .raw_in (raw_in[gi]),
            .clear  (bus.CLEAR),
            .level  (level[gi]),
            .fall   (fall[gi]),
            .rise   (rise[gi]),
            .count  (count[gi])
         );
      end
   endgenerate

   assign bus.DTR_LEVEL = level[CH_DTR];
   assign bus.RTS_LEVEL = level[CH_RTS];
   assign bus.DTR_FALL  = fall[CH_DTR];
   assign bus.DTR_RISE  = rise[CH_DTR];
   assign bus.RTS_FALL  = fall[CH_RTS];
   assign bus.RTS_RISE  = rise[CH_RTS];
   assign bus.DTR_COUNT = count[CH_DTR];
   assign bus.RTS_COUNT = count[CH_RTS];

`ifdef MODEM_CTL_ECHO_EN
   // Hardware acknowledge toward the host, one cycle behind the levels.
   logic dsr_reg;
   logic cts_reg;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         dsr_reg <= MODEM_IDLE_LEVEL;
         cts_reg <= MODEM_IDLE_LEVEL;
      end else begin
         dsr_reg <= level[CH_DTR];
         cts_reg <= level[CH_RTS];
      end
   end

   assign bus.DSR = dsr_reg;
   assign bus.CTS = cts_reg;
`endif

endmodule

// File: tb/tb_modem_ctl_monitor.sv
// Self-checking bench for modem_ctl_monitor (DEBOUNCE_CYCLES=4, COUNT_WIDTH=4).
module tb_modem_ctl_monitor;

   localparam int DB = 4;
   localparam int CW = 4;
   localparam int LAT = DB + 3;  // drive at negedge c -> pulse at edge c+1+2+DB

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   exp_q [2][$];
   int   rise_seen [2];
   int   mon_exp;
   int   mon_got;
   logic [1:0] obs_fall;
   logic [1:0] obs_rise;

   modem_ctl_monitor_if #(.COUNT_WIDTH(CW)) bus ();

   modem_ctl_monitor #(
      .DEBOUNCE_CYCLES (DB),
      .COUNT_WIDTH     (CW)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign obs_fall = {bus.RTS_FALL, bus.DTR_FALL};
   assign obs_rise = {bus.RTS_RISE, bus.DTR_RISE};

   // Scoreboard: each entry is (edge index * 2 + is_rise).
   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (exp_q[ch].size() > 0 && (exp_q[ch][0] >>> 1) < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse ch=%0d got=none want_cyc=%0d", ch, exp_q[ch][0] >>> 1);
            void'(exp_q[ch].pop_front());
         end
         if (obs_fall[ch] === 1'b1 || obs_rise[ch] === 1'b1) begin
            checks++;
            mon_got = cyc * 2 + ((obs_rise[ch] === 1'b1) ? 1 : 0);
            $display("txn ch=%0d edge=%s cyc=%0d", ch, (obs_rise[ch] === 1'b1) ? "rise" : "fall", cyc);
            if (obs_rise[ch] === 1'b1) rise_seen[ch]++;
            if (obs_fall[ch] === 1'b1 && obs_rise[ch] === 1'b1) begin
               errors++;
               $display("FAIL both_pulses ch=%0d got=fall+rise want=one", ch);
            end else if (exp_q[ch].size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse ch=%0d got=%0d want=none", ch, mon_got);
            end else begin
               mon_exp = exp_q[ch].pop_front();
               if (mon_got !== mon_exp) begin
                  errors++;
                  $display("FAIL pulse ch=%0d got=%0d want=%0d", ch, mon_got, mon_exp);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive a line at the current negedge and schedule its debounced edge.
   task automatic drive_line(input int ch, input logic val);
      if (ch == 0) bus.DTR = val;
      else         bus.RTS = val;
      exp_q[ch].push_back((cyc + LAT) * 2 + int'(val));
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(2);
      checks++;
      if ({bus.DTR_LEVEL, bus.RTS_LEVEL} !== 2'b11) begin
         errors++; $display("FAIL reset_levels got=%b want=11", {bus.DTR_LEVEL, bus.RTS_LEVEL});
      end
      checks++;
      if ({obs_fall, obs_rise} !== 4'b0) begin
         errors++; $display("FAIL reset_pulses got=%b want=0000", {obs_fall, obs_rise});
      end
      checks++;
      if (bus.DTR_COUNT !== 4'd0 || bus.RTS_COUNT !== 4'd0) begin
         errors++; $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.DTR_COUNT, bus.RTS_COUNT);
      end
`ifdef MODEM_CTL_ECHO_EN
      checks++;
      if ({bus.DSR, bus.CTS} !== 2'b11) begin
         errors++; $display("FAIL reset_echo got=%b want=11", {bus.DSR, bus.CTS});
      end
`endif
      rst = 1'b0;
      $display("txn reset done cyc=%0d", cyc);
   endtask

   task automatic test_clean_assert;
      drive_line(0, 1'b0);
      tick(LAT - 1);
      checks++;
      if (bus.DTR_LEVEL !== 1'b1) begin
         errors++; $display("FAIL clean_early_level got=%b want=1", bus.DTR_LEVEL);
      end
      tick(1);
      checks++;
      if (bus.DTR_LEVEL !== 1'b0 || bus.DTR_FALL !== 1'b1) begin
         errors++; $display("FAIL clean_edge got=%b%b want=01", bus.DTR_LEVEL, bus.DTR_FALL);
      end
`ifdef MODEM_CTL_ECHO_EN
      checks++;
      if (bus.DSR !== 1'b1) begin
         errors++; $display("FAIL echo_lag got=%b want=1", bus.DSR);
      end
`endif
      tick(1);
      checks++;
      if (bus.DTR_COUNT !== 4'd1 || bus.DTR_FALL !== 1'b0) begin
         errors++; $display("FAIL clean_count got=%0d/%b want=1/0", bus.DTR_COUNT, bus.DTR_FALL);
      end
      checks++;
      if (bus.RTS_LEVEL !== 1'b1 || bus.RTS_COUNT !== 4'd0) begin
         errors++; $display("FAIL clean_rts_quiet got=%b/%0d want=1/0", bus.RTS_LEVEL, bus.RTS_COUNT);
      end
`ifdef MODEM_CTL_ECHO_EN
      checks++;
      if (bus.DSR !== 1'b0) begin
         errors++; $display("FAIL echo_follow got=%b want=0", bus.DSR);
      end
`endif
      drive_line(0, 1'b1);
      tick(LAT + 1);
   endtask

   task automatic test_glitch;
      bus.RTS = 1'b0;
      tick(DB - 1);
      bus.RTS = 1'b1;
      tick(LAT + 3);
      checks++;
      if (bus.RTS_LEVEL !== 1'b1 || bus.RTS_COUNT !== 4'd0) begin
         errors++; $display("FAIL glitch_reject got=%b/%0d want=1/0", bus.RTS_LEVEL, bus.RTS_COUNT);
      end
      // A window of exactly DB synchronised samples qualifies, then rises back.
      exp_q[1].push_back((cyc + LAT) * 2);
      exp_q[1].push_back((cyc + LAT + DB) * 2 + 1);
      bus.RTS = 1'b0;
      tick(DB);
      bus.RTS = 1'b1;
      tick(LAT + 2);
      checks++;
      if (bus.RTS_LEVEL !== 1'b1 || bus.RTS_COUNT !== 4'd1) begin
         errors++; $display("FAIL glitch_min_window got=%b/%0d want=1/1", bus.RTS_LEVEL, bus.RTS_COUNT);
      end
   endtask

   task automatic test_wrap_and_parallel;
      int rises0;
      bus.CLEAR = 1'b1;
      tick(1);
      bus.CLEAR = 1'b0;
      checks++;
      if (bus.DTR_COUNT !== 4'd0 || bus.RTS_COUNT !== 4'd0) begin
         errors++; $display("FAIL clear_both got=%0d/%0d want=0/0", bus.DTR_COUNT, bus.RTS_COUNT);
      end
      rises0 = rise_seen[0];
      for (int i = 0; i < 16; i++) begin
         drive_line(0, 1'b0);
         if (i < 3) drive_line(1, 1'b0);
         tick(LAT + 1);
         drive_line(0, 1'b1);
         if (i < 3) drive_line(1, 1'b1);
         tick(LAT + 1);
         if (i == 14) begin
            checks++;
            if (bus.DTR_COUNT !== 4'd15) begin
               errors++; $display("FAIL wrap_top got=%0d want=15", bus.DTR_COUNT);
            end
         end
      end
      checks++;
      if (bus.DTR_COUNT !== 4'd0) begin
         errors++; $display("FAIL wrap_zero got=%0d want=0", bus.DTR_COUNT);
      end
      checks++;
      if (rise_seen[0] - rises0 !== 16) begin
         errors++; $display("FAIL wrap_rises got=%0d want=16", rise_seen[0] - rises0);
      end
      checks++;
      if (bus.RTS_COUNT !== 4'd3) begin
         errors++; $display("FAIL parallel_rts got=%0d want=3", bus.RTS_COUNT);
      end
   endtask

   task automatic test_clear_collision;
      for (int i = 0; i < 5; i++) begin
         drive_line(0, 1'b0);
         tick(LAT + 1);
         drive_line(0, 1'b1);
         tick(LAT + 1);
      end
      drive_line(0, 1'b0);
      tick(LAT);
      checks++;
      if (bus.DTR_FALL !== 1'b1 || bus.DTR_COUNT !== 4'd5) begin
         errors++; $display("FAIL collide_pre got=%b/%0d want=1/5", bus.DTR_FALL, bus.DTR_COUNT);
      end
      bus.CLEAR = 1'b1;
      tick(1);
      bus.CLEAR = 1'b0;
      checks++;
      if (bus.DTR_COUNT !== 4'd0 || bus.DTR_FALL !== 1'b0 || bus.DTR_LEVEL !== 1'b0) begin
         errors++; $display("FAIL collide_post got=%0d/%b/%b want=0/0/0", bus.DTR_COUNT, bus.DTR_FALL, bus.DTR_LEVEL);
      end
      drive_line(0, 1'b1);
      tick(LAT + 1);
   endtask

   task automatic test_reset_mid_debounce;
      bus.DTR = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if (bus.DTR_LEVEL !== 1'b1 || bus.DTR_COUNT !== 4'd0) begin
         errors++; $display("FAIL midreset_state got=%b/%0d want=1/0", bus.DTR_LEVEL, bus.DTR_COUNT);
      end
      exp_q[0].push_back((cyc + LAT) * 2);
      tick(LAT - 1);
      checks++;
      if (bus.DTR_LEVEL !== 1'b1) begin
         errors++; $display("FAIL midreset_early got=%b want=1", bus.DTR_LEVEL);
      end
      tick(1);
      checks++;
      if (bus.DTR_FALL !== 1'b1 || bus.DTR_LEVEL !== 1'b0) begin
         errors++; $display("FAIL midreset_fall got=%b/%b want=1/0", bus.DTR_FALL, bus.DTR_LEVEL);
      end
      drive_line(0, 1'b1);
      tick(LAT + 3);
   endtask

   initial begin
      bus.DTR   = 1'b1;
      bus.RTS   = 1'b1;
      bus.CLEAR = 1'b0;
      rise_seen[0] = 0;
      rise_seen[1] = 0;
      test_reset();
      tick(2);
      test_clean_assert();
      test_glitch();
      test_wrap_and_parallel();
      test_clear_collision();
      test_reset_mid_debounce();
      for (int ch = 0; ch < 2; ch++) begin
         checks++;
         if (exp_q[ch].size() != 0) begin
            errors++; $display("FAIL drained ch=%0d got=%0d want=0", ch, exp_q[ch].size());
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/modem_ctl_monitor.md
Name: modem_ctl_monitor

Overview:
- Receive-side companion to the board logic that drives DSR/CTS toward the host.
- Samples the host-driven FTDI modem-control inputs DTR and RTS, which are asynchronous and active-low. Each line is synchronised and debounced.
- Produces clean levels, one-cycle edge pulses and per-line assertion counters for LEDs and top-level control logic.
- Instantiated under main, clocked from CLKIN.

Parameters:
- DEBOUNCE_CYCLES, 12000, consecutive cycles a synchronised input must differ from the stable level before the level updates (1 ms at 12 MHz); legal range >= 1.
- COUNT_WIDTH, 8, width of each assertion counter.

Ports:
- CLK  input  1  system clock (CLKIN at top level)
- RESET  input  1  synchronous, active-high reset
- DTR  input  1  raw host DTR, active-low, asynchronous
- RTS  input  1  raw host RTS, active-low, asynchronous
- CLEAR  input  1  synchronous clear of both counters
- DTR_LEVEL  output  1  debounced DTR level
- RTS_LEVEL  output  1  debounced RTS level
- DTR_FALL / DTR_RISE  output  1 each  one-cycle pulse on debounced DTR 1->0 / 0->1
- RTS_FALL / RTS_RISE  output  1 each  one-cycle pulse on debounced RTS 1->0 / 0->1
- DTR_COUNT  output  COUNT_WIDTH  number of DTR assertions (falls)
- RTS_COUNT  output  COUNT_WIDTH  number of RTS assertions (falls)

Behaviour:
- Reset, while RESET=1 at a rising CLK edge:
  - both sync flops = 1 (idle/deasserted);
  - stable levels = 1, debounce counters = 0;
  - all pulses = 0, both COUNTs = 0.
- Synchroniser: 2-flop chain per line; sync output = second flop.
- Debounce, per channel, with counter width clog2(DEBOUNCE_CYCLES)+1:
  - if sync == stable: counter <= 0;
  - else if counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0, edge pulse asserted;
  - else: counter <= counter+1.
- Latency:
  - A clean input step first sampled at edge t makes LEVEL change, and the matching pulse assert, at edge t+2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no level change and no pulse.
  - Any bounce back to the stable value restarts the count from 0.
- Pulses:
  - registered, high for exactly one cycle, coincident with the LEVEL change;
  - FALL and RISE are never both high on one channel;
  - back-to-back edges are separated by at least DEBOUNCE_CYCLES cycles.
- Counters:
  - COUNT increments on the cycle its FALL pulse is high;
  - wraps from 2^COUNT_WIDTH-1 to 0, no saturation.
- CLEAR:
  - sets both COUNTs to 0 next edge;
  - CLEAR wins over a simultaneous FALL: count = 0, but the FALL pulse is still emitted;
  - CLEAR does not affect levels, debounce state or pulses.
- Channels are fully independent; simultaneous events on DTR and RTS are each handled in the same cycle.
- RESET mid-debounce discards progress. After release, an input still held low needs the full 2+DEBOUNCE_CYCLES cycles again.
- RESET has priority over CLEAR and all other updates.

Optional Feature:
- Macro: MODEM_CTL_ECHO_EN.
- Defined:
  - adds outputs DSR and CTS (1 bit each), registered copies of DTR_LEVEL and RTS_LEVEL;
  - one cycle behind the LEVEL outputs, reset value 1;
  - lets the board hardware-acknowledge host handshakes.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package:
  - MODEM_IDLE_LEVEL = 1'b1;
  - DEFAULT_DEBOUNCE_CYCLES = 12000;
  - DEFAULT_COUNT_WIDTH = 8;
  - channel index constants CH_DTR = 0, CH_RTS = 1.
- Sub-module modem_ctl_channel contains synchroniser, debounce counter, stable level, rise/fall pulses and assertion counter with CLEAR. It is instantiated twice.
- The top level wires the two channels and holds the optional echo registers.

Test Plan (DEBOUNCE_CYCLES=4, COUNT_WIDTH=4):
- Reset: RESET=1 for 2 cycles with DTR=RTS=1 -> LEVELs 1, all pulses 0, COUNTs 0; with MODEM_CTL_ECHO_EN, DSR=CTS=1.
- Clean assertion: DTR driven 0 before edge t and held -> DTR_FALL high only at edge t+6, DTR_LEVEL=0 from t+6, DTR_COUNT=1; RTS outputs unchanged.
- Glitch reject: RTS=0 for 3 cycles then 1 -> RTS_LEVEL stays 1, no pulses, RTS_COUNT=0. Repeating with a 4-cycle low window after sync produces a fall.
- Wrap: 16 debounced DTR assert/deassert cycles -> DTR_COUNT returns 0 and DTR_RISE fires 16 times. Simultaneously toggling RTS 3 times -> RTS_COUNT=3.
- CLEAR collision: CLEAR=1 on the cycle DTR_FALL fires with DTR_COUNT=5 -> DTR_COUNT=0 next cycle and DTR_FALL still seen for one cycle.
- Reset mid-debounce: DTR low 3 cycles, then RESET=1 for 1 cycle, DTR kept low -> no pulse before reset; after reset, DTR_FALL fires exactly 6 edges after the first post-reset sampling edge.
